// File: rtl/tcdm_bank_pipe_pkg.sv
// Shared types and widths for the per-bank TCDM pipeline slices.
package tcdm_bank_pipe_pkg;

   localparam int TCDM_ADDR_WIDTH = 32;
   localparam int TCDM_DATA_WIDTH = 32;

   function automatic int be_width(input int data_width);
      return data_width / 8;
   endfunction

   localparam int TCDM_BE_WIDTH = be_width(TCDM_DATA_WIDTH);

   typedef struct packed {
      logic [TCDM_ADDR_WIDTH-1:0] add;
      logic                       wen;
      logic [TCDM_DATA_WIDTH-1:0] wdata;
      logic [TCDM_BE_WIDTH-1:0]   be;
   } tcdm_req_t;

   // Encoded as {en_resp, en_req} of a slice.
   typedef enum logic [1:0] {
      BYPASS = 2'd0,
      REQ    = 2'd1,
      RESP   = 2'd2,
      BOTH   = 2'd3
   } pipe_mode_e;

endpackage

// File: rtl/tcdm_pipe_slice.sv
// One bank slice: optional request register, response tracking and optional response register.
// Enable inputs are adopted only while the slice is quiescent so nothing in flight is re-timed.
module tcdm_pipe_slice
   import tcdm_bank_pipe_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       en_req_cfg,
   input  logic                       en_resp_cfg,
   input  logic                       m_req,
   input  tcdm_req_t                  m_payload,
   output logic                       m_gnt,
   output logic                       m_r_valid,
   output logic [TCDM_DATA_WIDTH-1:0] m_r_rdata,
   output logic                       s_req,
   output tcdm_req_t                  s_payload,
   input  logic                       s_gnt,
   input  logic [TCDM_DATA_WIDTH-1:0] s_r_rdata,
   output logic                       pipe_idle
);

   logic                       en_req_r;
   logic                       en_resp_r;
   logic                       valid_r;
   tcdm_req_t                  req_r;
   logic                       pend_r;
   logic                       pend_read_r;
   logic                       rvalid_r;
   logic [TCDM_DATA_WIDTH-1:0] rdata_r;

   logic                       quiescent_s;
   logic                       fill_s;
   logic [TCDM_DATA_WIDTH-1:0] resp_data_s;

   assign quiescent_s = ~valid_r & ~pend_r & ~rvalid_r & ~m_req;
   assign resp_data_s = (pend_r & pend_read_r) ? s_r_rdata : {TCDM_DATA_WIDTH{1'b0}};
   assign pipe_idle   = quiescent_s & (en_req_r == en_req_cfg) & (en_resp_r == en_resp_cfg);

   // Request-side muxing: wires in bypass, one-entry register otherwise; forced low in reset.
   always_comb begin
      s_req     = 1'b0;
      s_payload = '0;
      m_gnt     = 1'b0;
      fill_s    = 1'b0;
      if (!rst_n) begin
         s_req     = 1'b0;
         s_payload = '0;
         m_gnt     = 1'b0;
      end else if (en_req_r) begin
         s_req     = valid_r;
         s_payload = req_r;
         m_gnt     = ~valid_r | s_gnt;
         fill_s    = m_req & (~valid_r | s_gnt);
      end else begin
         s_req     = m_req;
         s_payload = m_payload;
         m_gnt     = s_gnt;
      end
   end

   // Response-side muxing between the pending-response path and its registered copy.
   always_comb begin
      m_r_valid = 1'b0;
      m_r_rdata = {TCDM_DATA_WIDTH{1'b0}};
      if (en_resp_r) begin
         m_r_valid = rvalid_r;
         m_r_rdata = rdata_r;
      end else begin
         m_r_valid = pend_r;
         m_r_rdata = resp_data_s;
      end
   end

   // Effective enables follow the configuration only in quiescent cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_req_r  <= 1'b0;
         en_resp_r <= 1'b0;
      end else if (quiescent_s) begin
         en_req_r  <= en_req_cfg;
         en_resp_r <= en_resp_cfg;
      end
   end

   // Request register: fall-through fill on simultaneous drain, clear on drain alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_r <= 1'b0;
         req_r   <= '0;
      end else if (fill_s) begin
         valid_r <= 1'b1;
         req_r   <= m_payload;
      end else if (s_gnt) begin
         valid_r <= 1'b0;
      end
   end

   // Bank handshake tracking and optional response register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_r      <= 1'b0;
         pend_read_r <= 1'b0;
         rvalid_r    <= 1'b0;
         rdata_r     <= {TCDM_DATA_WIDTH{1'b0}};
      end else begin
         pend_r      <= s_req & s_gnt;
         pend_read_r <= s_payload.wen;
         rvalid_r    <= en_resp_r & pend_r;
         rdata_r     <= en_resp_r ? resp_data_s : {TCDM_DATA_WIDTH{1'b0}};
      end
   end

endmodule

// File: rtl/tcdm_bank_pipe.sv
// Array of per-bank pipeline slices between the TCDM crossbar and the SRAM banks.
module tcdm_bank_pipe
   import tcdm_bank_pipe_pkg::*;
#(
   parameter  int N_SLAVE    = 16,
   parameter  int ADDR_WIDTH = TCDM_ADDR_WIDTH,
   parameter  int DATA_WIDTH = TCDM_DATA_WIDTH,
   localparam int BE_WIDTH   = be_width(DATA_WIDTH)
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic [N_SLAVE-1:0]               enable_req_pipe_i,
   input  logic [N_SLAVE-1:0]               enable_resp_pipe_i,
   input  logic [N_SLAVE-1:0]               m_req_i,
   input  logic [N_SLAVE*ADDR_WIDTH-1:0]    m_add_i,
   input  logic [N_SLAVE-1:0]               m_wen_i,
   input  logic [N_SLAVE*DATA_WIDTH-1:0]    m_wdata_i,
   input  logic [N_SLAVE*BE_WIDTH-1:0]      m_be_i,
   output logic [N_SLAVE-1:0]               m_gnt_o,
   output logic [N_SLAVE-1:0]               m_r_valid_o,
   output logic [N_SLAVE*DATA_WIDTH-1:0]    m_r_rdata_o,
   output logic [N_SLAVE-1:0]               s_req_o,
   output logic [N_SLAVE*ADDR_WIDTH-1:0]    s_add_o,
   output logic [N_SLAVE-1:0]               s_wen_o,
   output logic [N_SLAVE*DATA_WIDTH-1:0]    s_wdata_o,
   output logic [N_SLAVE*BE_WIDTH-1:0]      s_be_o,
   input  logic [N_SLAVE-1:0]               s_gnt_i,
   input  logic [N_SLAVE*DATA_WIDTH-1:0]    s_r_rdata_i,
   output logic [N_SLAVE-1:0]               pipe_idle_o
);

   for (genvar g = 0; g < N_SLAVE; g++) begin : g_slice
      tcdm_req_t m_pl;
      tcdm_req_t s_pl;

      assign m_pl.add   = m_add_i[g*ADDR_WIDTH +: ADDR_WIDTH];
      assign m_pl.wen   = m_wen_i[g];
      assign m_pl.wdata = m_wdata_i[g*DATA_WIDTH +: DATA_WIDTH];
      assign m_pl.be    = m_be_i[g*BE_WIDTH +: BE_WIDTH];

      tcdm_pipe_slice u_slice (
         .clk         (clk_i),
         .rst_n       (rst_ni),
         .en_req_cfg  (enable_req_pipe_i[g]),
         .en_resp_cfg (enable_resp_pipe_i[g]),
         .m_req       (m_req_i[g]),
         .m_payload   (m_pl),
         .m_gnt       (m_gnt_o[g]),
         .m_r_valid   (m_r_valid_o[g]),
         .m_r_rdata   (m_r_rdata_o[g*DATA_WIDTH +: DATA_WIDTH]),
         .s_req       (s_req_o[g]),
         .s_payload   (s_pl),
         .s_gnt       (s_gnt_i[g]),
         .s_r_rdata   (s_r_rdata_i[g*DATA_WIDTH +: DATA_WIDTH]),
         .pipe_idle   (pipe_idle_o[g])
      );

      assign s_add_o[g*ADDR_WIDTH +: ADDR_WIDTH]   = s_pl.add;
      assign s_wen_o[g]                            = s_pl.wen;
      assign s_wdata_o[g*DATA_WIDTH +: DATA_WIDTH] = s_pl.wdata;
      assign s_be_o[g*BE_WIDTH +: BE_WIDTH]        = s_pl.be;
   end

endmodule

// File: tb/tb_tcdm_bank_pipe.sv
// Directed bench for tcdm_bank_pipe: bypass, pipelined and mode-switch behaviour plus reset.
module tb_tcdm_bank_pipe;

   localparam int N  = 16;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int BW = 4;

   logic            clk = 1'b0;
   logic            rst_ni;
   logic [N-1:0]    enable_req_pipe_i;
   logic [N-1:0]    enable_resp_pipe_i;
   logic [N-1:0]    m_req_i;
   logic [N*AW-1:0] m_add_i;
   logic [N-1:0]    m_wen_i;
   logic [N*DW-1:0] m_wdata_i;
   logic [N*BW-1:0] m_be_i;
   logic [N-1:0]    m_gnt_o;
   logic [N-1:0]    m_r_valid_o;
   logic [N*DW-1:0] m_r_rdata_o;
   logic [N-1:0]    s_req_o;
   logic [N*AW-1:0] s_add_o;
   logic [N-1:0]    s_wen_o;
   logic [N*DW-1:0] s_wdata_o;
   logic [N*BW-1:0] s_be_o;
   logic [N-1:0]    s_gnt_i;
   logic [N*DW-1:0] s_r_rdata_i;
   logic [N-1:0]    pipe_idle_o;

   int n_cmp = 0;
   int n_err = 0;

   logic [DW-1:0] bank_rdata [N];

   always #5 clk = ~clk;

   tcdm_bank_pipe dut (
      .clk_i              (clk),
      .rst_ni             (rst_ni),
      .enable_req_pipe_i  (enable_req_pipe_i),
      .enable_resp_pipe_i (enable_resp_pipe_i),
      .m_req_i            (m_req_i),
      .m_add_i            (m_add_i),
      .m_wen_i            (m_wen_i),
      .m_wdata_i          (m_wdata_i),
      .m_be_i             (m_be_i),
      .m_gnt_o            (m_gnt_o),
      .m_r_valid_o        (m_r_valid_o),
      .m_r_rdata_o        (m_r_rdata_o),
      .s_req_o            (s_req_o),
      .s_add_o            (s_add_o),
      .s_wen_o            (s_wen_o),
      .s_wdata_o          (s_wdata_o),
      .s_be_o             (s_be_o),
      .s_gnt_i            (s_gnt_i),
      .s_r_rdata_i        (s_r_rdata_i),
      .pipe_idle_o        (pipe_idle_o)
   );

   // SRAM bank model: data = 0xCAFE0000 + addr/16 one cycle after a handshake, garbage otherwise.
   always_ff @(posedge clk) begin
      for (int b = 0; b < N; b++) begin
         if (s_req_o[b] && s_gnt_i[b])
            bank_rdata[b] <= 32'hCAFE0000 + (s_add_o[b*AW +: AW] >> 4);
         else
            bank_rdata[b] <= 32'hDEAD0000 + 32'(b);
      end
   end

   for (genvar g = 0; g < N; g++) begin : g_rd
      assign s_r_rdata_i[g*DW +: DW] = bank_rdata[g];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_m(input int b, input logic req, input logic [31:0] add, input logic wen,
                        input logic [31:0] wdata, input logic [3:0] be);
      m_req_i[b]            = req;
      m_add_i[b*AW +: AW]   = add;
      m_wen_i[b]            = wen;
      m_wdata_i[b*DW +: DW] = wdata;
      m_be_i[b*BW +: BW]    = be;
   endtask

   function automatic logic [31:0] rd(input int b);
      return m_r_rdata_o[b*DW +: DW];
   endfunction

   function automatic logic [31:0] sadd(input int b);
      return s_add_o[b*AW +: AW];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   initial begin
      rst_ni             = 1'b0;
      enable_req_pipe_i  = '0;
      enable_resp_pipe_i = '0;
      m_req_i            = '0;
      m_add_i            = '0;
      m_wen_i            = '0;
      m_wdata_i          = '0;
      m_be_i             = '0;
      s_gnt_i            = '0;

      // Reset values
      #2;
      chk("rst_gnt", 32'(m_gnt_o), 32'h0);
      chk("rst_rvalid", 32'(m_r_valid_o), 32'h0);
      chk("rst_sreq", 32'(s_req_o), 32'h0);
      chk("rst_idle", 32'(pipe_idle_o), 32'h0000FFFF);
      chk("rst_rdata0", rd(0), 32'h0);
      smp();
      smp();
      rst_ni = 1'b1;

      // Bypass read on bank 0
      step();
      set_m(0, 1'b1, 32'h10, 1'b1, 32'h0, 4'h0);
      s_gnt_i[0] = 1'b1;
      smp();
      chk("byp_sreq", 32'(s_req_o[0]), 32'h1);
      chk("byp_sadd", sadd(0), 32'h10);
      chk("byp_gnt", 32'(m_gnt_o[0]), 32'h1);
      chk("byp_idle_busy", 32'(pipe_idle_o[0]), 32'h0);
      step();
      set_m(0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
      smp();
      chk("byp_rvalid", 32'(m_r_valid_o[0]), 32'h1);
      chk("byp_rdata", rd(0), 32'hCAFE0001);
      step();
      smp();
      chk("byp_rvalid_off", 32'(m_r_valid_o[0]), 32'h0);

      // Bank 3 with both registers: 8 back-to-back reads, latency 3
      step();
      enable_req_pipe_i[3]  = 1'b1;
      enable_resp_pipe_i[3] = 1'b1;
      s_gnt_i[3]            = 1'b1;
      smp();
      chk("both_idle_pending", 32'(pipe_idle_o[3]), 32'h0);
      step();
      smp();
      chk("both_idle_loaded", 32'(pipe_idle_o[3]), 32'h1);
      for (int i = 0; i < 12; i++) begin
         step();
         if (i < 8) set_m(3, 1'b1, 32'((i + 1) << 4), 1'b1, 32'h0, 4'h0);
         else       set_m(3, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
         smp();
         if (i == 0) chk("both_sreq_delay", 32'(s_req_o[3]), 32'h0);
         if (i < 8)  chk("both_gnt", 32'(m_gnt_o[3]), 32'h1);
         chk("both_rvalid", 32'(m_r_valid_o[3]), (i >= 3 && i < 11) ? 32'h1 : 32'h0);
         if (i >= 3 && i < 11) chk("both_rdata", rd(3), 32'hCAFE0000 + 32'(i - 2));
      end

      // Enable request pipe on bank 0 while it streams reads
      for (int c = 0; c < 10; c++) begin
         step();
         if (c < 4)       set_m(0, 1'b1, 32'((c + 32'h20) << 4), 1'b1, 32'h0, 4'h0);
         else if (c == 7) set_m(0, 1'b1, 32'h300, 1'b1, 32'h0, 4'h0);
         else             set_m(0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
         if (c == 1) enable_req_pipe_i[0] = 1'b1;
         smp();
         if (c <= 6) chk("sw_idle", 32'(pipe_idle_o[0]), (c == 6) ? 32'h1 : 32'h0);
         chk("sw_rvalid", 32'(m_r_valid_o[0]), ((c >= 1 && c <= 4) || c == 9) ? 32'h1 : 32'h0);
         if (c >= 1 && c <= 4) chk("sw_rdata", rd(0), 32'hCAFE0020 + 32'(c - 1));
         if (c == 7) begin
            chk("sw_sreq_reg", 32'(s_req_o[0]), 32'h0);
            chk("sw_gnt_reg", 32'(m_gnt_o[0]), 32'h1);
         end
         if (c == 8) chk("sw_sadd_reg", sadd(0), 32'h300);
         if (c == 9) chk("sw_rdata_reg", rd(0), 32'hCAFE0030);
      end

      // Request pipe full with bank grant withheld for 4 cycles
      step();
      set_m(0, 1'b1, 32'h400, 1'b1, 32'h0, 4'h0);
      s_gnt_i[0] = 1'b0;
      smp();
      chk("bp_gnt_empty", 32'(m_gnt_o[0]), 32'h1);
      chk("bp_sreq_empty", 32'(s_req_o[0]), 32'h0);
      for (int d = 1; d < 4; d++) begin
         step();
         set_m(0, 1'b1, 32'h410, 1'b1, 32'h0, 4'h0);
         smp();
         chk("bp_gnt_full", 32'(m_gnt_o[0]), 32'h0);
         chk("bp_sreq_full", 32'(s_req_o[0]), 32'h1);
         chk("bp_sadd_full", sadd(0), 32'h400);
      end
      step();
      s_gnt_i[0] = 1'b1;
      smp();
      chk("bp_gnt_release", 32'(m_gnt_o[0]), 32'h1);
      chk("bp_sadd_release", sadd(0), 32'h400);
      step();
      set_m(0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
      smp();
      chk("bp_sadd_next", sadd(0), 32'h410);
      chk("bp_rvalid_a", 32'(m_r_valid_o[0]), 32'h1);
      chk("bp_rdata_a", rd(0), 32'hCAFE0040);
      step();
      smp();
      chk("bp_rvalid_b", 32'(m_r_valid_o[0]), 32'h1);
      chk("bp_rdata_b", rd(0), 32'hCAFE0041);
      chk("bp_sreq_drained", 32'(s_req_o[0]), 32'h0);
      step();
      smp();
      chk("bp_rvalid_end", 32'(m_r_valid_o[0]), 32'h0);

      // Bypass write on bank 5
      step();
      set_m(5, 1'b1, 32'h500, 1'b0, 32'h11223344, 4'b0101);
      s_gnt_i[5] = 1'b1;
      smp();
      chk("wr_sreq", 32'(s_req_o[5]), 32'h1);
      chk("wr_swen", 32'(s_wen_o[5]), 32'h0);
      chk("wr_sbe", 32'(s_be_o[5*BW +: BW]), 32'h5);
      chk("wr_swdata", s_wdata_o[5*DW +: DW], 32'h11223344);
      step();
      set_m(5, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
      smp();
      chk("wr_rvalid", 32'(m_r_valid_o[5]), 32'h1);
      chk("wr_rdata", rd(5), 32'h0);

      // Reset with request register full and response pending on bank 3
      step();
      set_m(3, 1'b1, 32'h600, 1'b1, 32'h0, 4'h0);
      smp();
      step();
      set_m(3, 1'b1, 32'h610, 1'b1, 32'h0, 4'h0);
      smp();
      chk("rm_sreq", 32'(s_req_o[3]), 32'h1);
      chk("rm_gnt_ft", 32'(m_gnt_o[3]), 32'h1);
      step();
      set_m(3, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
      s_gnt_i[3]         = 1'b0;
      enable_req_pipe_i  = '0;
      enable_resp_pipe_i = '0;
      smp();
      chk("rm_full", 32'(s_req_o[3]), 32'h1);
      chk("rm_full_add", sadd(3), 32'h610);
      #1;
      rst_ni = 1'b0;
      #1;
      chk("rm_rst_sreq", 32'(s_req_o), 32'h0);
      chk("rm_rst_gnt", 32'(m_gnt_o), 32'h0);
      chk("rm_rst_rvalid", 32'(m_r_valid_o), 32'h0);
      chk("rm_rst_rdata3", rd(3), 32'h0);
      chk("rm_rst_idle", 32'(pipe_idle_o), 32'h0000FFFF);
      smp();
      rst_ni = 1'b1;
      #1;
      chk("rm_post_idle", 32'(pipe_idle_o), 32'h0000FFFF);
      step();
      smp();
      chk("rm_no_stale", 32'(m_r_valid_o[3]), 32'h0);
      step();
      set_m(3, 1'b1, 32'h700, 1'b1, 32'h0, 4'h0);
      s_gnt_i[3] = 1'b1;
      smp();
      chk("rm_byp_sreq", 32'(s_req_o[3]), 32'h1);
      step();
      set_m(3, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
      smp();
      chk("rm_byp_rvalid", 32'(m_r_valid_o[3]), 32'h1);
      chk("rm_byp_rdata", rd(3), 32'hCAFE0070);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
